cpu_bus_bridge: RTL and testbench

Single-outstanding bridge between the multicycle CPU controller's bus strobes (bus_read / bus_write / byteenable, address from the PC/MAR mux) and the system Wishbone-style memory bus. It generates the controller's bus_wait, runs one external cycle per request, and holds read data stable for the controller's latch cycle. It also converts bus errors and hangs into a sticky fault.

---
 rtl/cpu_bus_bridge.sv | 131 +++++++++++++
 tb/tb_cpu_bus_bridge.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module      : cpu_bus_bridge
// Description : Single-outstanding bridge from the multicycle CPU bus strobes
//               to a Wishbone-style memory bus. Generates bus_wait for the
//               controller, runs exactly one external cycle per request, holds
//               read data stable while the CPU keeps its strobe high, and turns
//               bus errors and unacknowledged strobes into a sticky fault.
// Ports       : clock, reset            - clock, synchronous active-high reset
//               cpu_addr/writedata/be   - CPU request address, data, lanes
//               bus_read, bus_write     - CPU request strobes
//               bus_wait                - request pending (to controller)
//               cpu_readdata            - registered read data
//               bus_fault               - sticky error / timeout flag
//               wb_cyc/stb/we/adr/sel   - external bus master outputs
//               wb_dat_o, wb_dat_i      - external write / read data
//               wb_ack, wb_err          - external completion / error
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_bus_bridge #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_writedata,
    input  logic [3:0]  cpu_byteenable,
    input  logic        bus_read,
    input  logic        bus_write,
    output logic        bus_wait,
    output logic [31:0] cpu_readdata,
    output logic        bus_fault,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [31:0] wb_adr,
    output logic [3:0]  wb_sel,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack,
    input  logic        wb_err
);

    // Counter must be able to reach TIMEOUT itself.
    localparam int unsigned    CW        = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  c_TIMEOUT = CW'(TIMEOUT);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_CYCLE = 2'd1;
    localparam logic [1:0] c_HOLD  = 2'd2;

    logic [1:0]    r_state;
    logic [CW-1:0] r_count;
    logic          w_req;

    assign w_req = bus_read | bus_write;

    // In IDLE the wait follows the strobes combinationally so the controller
    // never sees wait low in the cycle it raises a request.
    always_comb begin
        bus_wait = 1'b0;
        case (r_state)
            c_IDLE:  bus_wait = w_req;
            c_CYCLE: bus_wait = 1'b1;
            default: bus_wait = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_count      <= '0;
            wb_cyc       <= 1'b0;
            wb_stb       <= 1'b0;
            wb_we        <= 1'b0;
            wb_adr       <= '0;
            wb_sel       <= '0;
            wb_dat_o     <= '0;
            cpu_readdata <= '0;
            bus_fault    <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_req) begin
                        wb_adr   <= cpu_addr;
                        wb_sel   <= cpu_byteenable;
                        wb_dat_o <= cpu_writedata;
                        wb_we    <= bus_write;   // write wins when both strobes are high
                        wb_cyc   <= 1'b1;
                        wb_stb   <= 1'b1;
                        r_count  <= '0;
                        r_state  <= c_CYCLE;
                    end
                end
                c_CYCLE: begin
                    // Ack takes priority over a simultaneous error or timeout.
                    if (wb_ack) begin
                        wb_cyc  <= 1'b0;
                        wb_stb  <= 1'b0;
                        if (!wb_we) begin
                            cpu_readdata <= wb_dat_i;
                        end
                        r_state <= c_HOLD;
                    end else if (wb_err || (r_count == c_TIMEOUT)) begin
                        wb_cyc       <= 1'b0;
                        wb_stb       <= 1'b0;
                        bus_fault    <= 1'b1;
                        cpu_readdata <= 32'hFFFF_FFFF;
                        r_state      <= c_HOLD;
                    end else begin
                        r_count <= r_count + CW'(1);
                    end
                end
                c_HOLD: begin
                    // A strobe still held from the finished request must not
                    // start a second transfer.
                    if (!w_req) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    wb_cyc  <= 1'b0;
                    wb_stb  <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_bus_bridge
// Description : Self-checking bench for cpu_bus_bridge. Directed scenarios
//               followed by randomized transfers; the bench plays the memory
//               and predicts per-cycle strobe/wait behaviour from the transfer
//               outcome (response cycle, kind) rather than from any FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_bus_bridge;

    localparam int TO = 4;

    // response kinds
    localparam int K_ACK     = 0;
    localparam int K_ERR     = 1;
    localparam int K_TIMEOUT = 2;
    localparam int K_ACKERR  = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_writedata;
    logic [3:0]  cpu_byteenable;
    logic        bus_read;
    logic        bus_write;
    logic        bus_wait;
    logic [31:0] cpu_readdata;
    logic        bus_fault;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [31:0] wb_adr;
    logic [3:0]  wb_sel;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack;
    logic        wb_err;

    int vectors     = 0;
    int miscompares = 0;

    // reference model state
    logic [31:0] exp_rd;
    logic        exp_fault;

    cpu_bus_bridge #(.TIMEOUT(TO)) dut (
        .clock          (clock),
        .reset          (reset),
        .cpu_addr       (cpu_addr),
        .cpu_writedata  (cpu_writedata),
        .cpu_byteenable (cpu_byteenable),
        .bus_read       (bus_read),
        .bus_write      (bus_write),
        .bus_wait       (bus_wait),
        .cpu_readdata   (cpu_readdata),
        .bus_fault      (bus_fault),
        .wb_cyc         (wb_cyc),
        .wb_stb         (wb_stb),
        .wb_we          (wb_we),
        .wb_adr         (wb_adr),
        .wb_sel         (wb_sel),
        .wb_dat_o       (wb_dat_o),
        .wb_dat_i       (wb_dat_i),
        .wb_ack         (wb_ack),
        .wb_err         (wb_err)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One complete CPU transfer. Entered and left in an IDLE cycle just after
    // a rising edge. delay = cycle (counted from first stb cycle = 1) in which
    // the memory responds; ignored for timeouts. hold_extra = extra cycles the
    // CPU keeps its strobe high after bus_wait falls.
    task automatic xfer(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int kind,
                        input int delay, input int hold_extra);
        int  end_c;
        bit  exp_we;
        end_c  = (kind == K_TIMEOUT) ? TO + 1 : delay;
        exp_we = wr;

        // outcome of the whole transfer
        if (kind == K_ACK || kind == K_ACKERR) begin
            if (!wr) exp_rd = rdata;
        end else begin
            exp_fault = 1'b1;
            exp_rd    = 32'hFFFF_FFFF;
        end

        bus_read       = rd;
        bus_write      = wr;
        cpu_addr       = addr;
        cpu_byteenable = be;
        cpu_writedata  = wdata;
        @(negedge clock);
        check("req_cycle_wait", bus_wait, 1);
        check("req_cycle_stb", wb_stb, 0);

        for (int c = 1; c <= end_c + 1; c++) begin
            step();
            // later CPU-side changes must not reach the bus
            cpu_addr       = $urandom;
            cpu_writedata  = $urandom;
            cpu_byteenable = 4'($urandom);
            wb_ack   = (kind == K_ACK || kind == K_ACKERR) && (c == delay);
            wb_err   = (kind == K_ERR || kind == K_ACKERR) && (c == delay);
            wb_dat_i = wb_ack ? rdata : $urandom;
            @(negedge clock);
            if (c <= end_c) begin
                check("cyc_stb", wb_stb, 1);
                check("cyc_cyc", wb_cyc, 1);
                check("cyc_wait", bus_wait, 1);
                check("cyc_adr", wb_adr, addr);
                check("cyc_sel", wb_sel, be);
                check("cyc_dat_o", wb_dat_o, wdata);
                check("cyc_we", wb_we, exp_we);
            end else begin
                check("done_stb", wb_stb, 0);
                check("done_wait", bus_wait, 0);
                check("done_rdata", cpu_readdata, exp_rd);
                check("done_fault", bus_fault, exp_fault);
            end
        end

        for (int h = 0; h < hold_extra; h++) begin
            step();
            wb_ack   = 1'b0;
            wb_err   = 1'b0;
            wb_dat_i = $urandom;
            @(negedge clock);
            check("hold_stb", wb_stb, 0);
            check("hold_wait", bus_wait, 0);
            check("hold_rdata", cpu_readdata, exp_rd);
        end

        step();
        bus_read  = 1'b0;
        bus_write = 1'b0;
        wb_ack    = 1'b0;
        wb_err    = 1'b0;
        @(negedge clock);
        check("drop_wait", bus_wait, 0);
        check("drop_cyc", wb_cyc, 0);
        check("drop_rdata", cpu_readdata, exp_rd);
        step();
    endtask

    initial begin
        reset          = 1'b1;
        bus_read       = 1'b0;
        bus_write      = 1'b0;
        cpu_addr       = '0;
        cpu_writedata  = '0;
        cpu_byteenable = '0;
        wb_dat_i       = '0;
        wb_ack         = 1'b0;
        wb_err         = 1'b0;
        exp_rd         = '0;
        exp_fault      = 1'b0;

        // reset values
        step();
        step();
        @(negedge clock);
        check("rst_cyc", wb_cyc, 0);
        check("rst_stb", wb_stb, 0);
        check("rst_we", wb_we, 0);
        check("rst_adr", wb_adr, 0);
        check("rst_sel", wb_sel, 0);
        check("rst_dat_o", wb_dat_o, 0);
        check("rst_rdata", cpu_readdata, 0);
        check("rst_fault", bus_fault, 0);
        check("rst_wait_idle", bus_wait, 0);
        bus_read = 1'b1;
        #1;
        check("rst_wait_follows", bus_wait, 1);
        step();
        bus_read = 1'b0;
        reset    = 1'b0;
        step();

        // zero-wait read
        xfer(1, 0, 32'h100, 4'hF, 32'h0, 32'hDEAD_BEEF, K_ACK, 1, 1);
        // write, ack after 3 wait cycles
        xfer(0, 1, 32'h200, 4'b0011, 32'h1234_5678, 32'hAAAA_5555, K_ACK, 4, 0);
        // fetch-like pattern, minimum gap
        xfer(1, 0, 32'h100, 4'hF, 32'h0, 32'h0000_0013, K_ACK, 1, 1);
        xfer(1, 0, 32'h104, 4'hF, 32'h0, 32'h0000_0093, K_ACK, 1, 0);
        // ack in the timeout cycle still wins
        xfer(1, 0, 32'h108, 4'hF, 32'h0, 32'h0BAD_F00D, K_ACK, TO + 1, 0);
        // both strobes: write wins
        xfer(1, 1, 32'h10C, 4'b1000, 32'hCAFE_0000, 32'h1111_1111, K_ACK, 2, 0);
        // ack and err together: ack wins, no fault
        xfer(1, 0, 32'h110, 4'hF, 32'h0, 32'h7777_8888, K_ACKERR, 3, 0);
        // error on a read
        xfer(1, 0, 32'h114, 4'hF, 32'h0, 32'h0, K_ERR, 2, 1);
        // timeout
        xfer(1, 0, 32'h118, 4'hF, 32'h0, 32'h0, K_TIMEOUT, 0, 0);
        // fault stays set across a good write
        xfer(0, 1, 32'h11C, 4'hF, 32'h5A5A_5A5A, 32'h0, K_ACK, 1, 0);

        // reset two cycles into a pending read
        bus_read = 1'b1;
        cpu_addr = 32'h300;
        step();                 // cycle 1
        step();                 // cycle 2
        reset = 1'b1;
        @(negedge clock);
        check("rstmid_stb_before", wb_stb, 1);
        step();                 // cycle 3: IDLE, reset still held
        exp_rd    = '0;
        exp_fault = 1'b0;
        @(negedge clock);
        check("rstmid_cyc", wb_cyc, 0);
        check("rstmid_stb", wb_stb, 0);
        check("rstmid_wait_idle", bus_wait, 1);
        check("rstmid_fault", bus_fault, 0);
        step();                 // cycle 4: late ack, no strobes
        reset    = 1'b0;
        bus_read = 1'b0;
        wb_ack   = 1'b1;
        wb_dat_i = 32'hBAD0_BAD0;
        @(negedge clock);
        check("late_ack_wait", bus_wait, 0);
        step();
        wb_ack = 1'b0;
        @(negedge clock);
        check("late_ack_cyc", wb_cyc, 0);
        check("late_ack_rdata", cpu_readdata, 0);
        check("late_ack_fault", bus_fault, 0);
        step();
        xfer(1, 0, 32'h300, 4'hF, 32'h0, 32'h3141_5926, K_ACK, 2, 0);

        // randomized transfers
        for (int n = 0; n < 60; n++) begin
            int  mode;
            int  r;
            int  kind;
            mode = $urandom_range(0, 2);
            r    = $urandom_range(0, 7);
            kind = (r <= 4) ? K_ACK : (r == 5) ? K_ERR : (r == 6) ? K_TIMEOUT : K_ACKERR;
            xfer(mode != 1, mode != 0, $urandom, 4'($urandom), $urandom, $urandom,
                 kind, $urandom_range(1, TO + 1), $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
